// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and defaults for the front-panel instruction entry loader.
//   state_t              : loader FSM state encoding (also driven to State_Out)
//   DEF_DEBOUNCE_CYCLES  : default debounce length (5 ms at 50 MHz)
//   DEF_DATA_W           : default instruction word width
//   DEF_ADDR_W           : default instruction memory address width
//   nib_count_w()        : width of the nibble counter for a given word width
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_DATA_W          = 16;
    localparam int DEF_ADDR_W          = 8;

    // A single-nibble word still needs a 1-bit counter to keep ports legal.
    function automatic int nib_count_w(input int data_w);
        return (data_w / 4 > 1) ? $clog2(data_w / 4) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronizes a raw active-low pushbutton, debounces it and emits a single
// cycle pulse when the debounced level falls (key pressed).
// Ports:
//   i_Clk    : system clock
//   i_Reset  : synchronous active-low reset (debounced level -> released)
//   i_Key    : raw active-low key, asynchronous to i_Clk
//   o_Press  : 1-cycle press pulse, registered
// ---------------------------------------------------------------------------
module key_debounce
    import loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Key,
    output logic o_Press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_count <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_Key;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Count consecutive cycles of disagreement; any return to the
            // current level (a bounce) restarts the count.
            if (r_sync2 != r_level) begin
                if (r_count == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_count <= '0;
                    r_press <= ~r_sync2;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else begin
                r_count <= '0;
            end
        end
    end

    assign o_Press = r_press;

endmodule

// File: rtl/instr_entry_loader.sv
// ---------------------------------------------------------------------------
// instr_entry_loader
// Operator keys instruction words in one hex nibble per Enter press; every
// DATA_W/4 nibbles the word is written to instruction memory through a
// request/acknowledge handshake at an auto-incrementing address.
// Optional build macro: LOADER_CHECKSUM_EN adds o_Checksum, the XOR of all
// accepted write data.
// Ports:
//   i_Clk          : system clock
//   i_Reset        : synchronous active-low reset
//   i_Key_Enter    : raw active-low Enter key (captures i_Sw_Nibble)
//   i_Key_Clear    : raw active-low Clear key (aborts a partial word)
//   i_Sw_Nibble    : hex digit from the switches
//   i_Wr_Ack       : memory accepted the current write
//   o_Wr_Req       : write request
//   o_Wr_Addr      : write address
//   o_Wr_Data      : write data
//   o_Entry_Word   : word under construction (for the hex display)
//   o_Nib_Count    : nibbles captured so far
//   o_State_Out    : 0 = ENTRY, 1 = WRITE, 2 = FULL
//   o_Full         : memory exhausted
//   o_Checksum     : XOR of accepted write data (LOADER_CHECKSUM_EN only)
// ---------------------------------------------------------------------------
module instr_entry_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W          = DEF_ADDR_W,
    parameter int                DATA_W          = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] START_ADDR      = '0,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    localparam int               NC_W            = nib_count_w(DATA_W)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Key_Enter,
    input  logic              i_Key_Clear,
    input  logic [3:0]        i_Sw_Nibble,
    input  logic              i_Wr_Ack,
    output logic              o_Wr_Req,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [DATA_W-1:0] o_Wr_Data,
    output logic [DATA_W-1:0] o_Entry_Word,
    output logic [NC_W-1:0]   o_Nib_Count,
    output logic [1:0]        o_State_Out,
    output logic              o_Full
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] o_Checksum
`endif
);

    localparam logic [NC_W-1:0] NIB_LAST = NC_W'(DATA_W / 4 - 1);

    // Bit 0 = Enter, bit 1 = Clear.
    logic [1:0]        w_raw_keys;
    logic [1:0]        w_press;
    logic              w_enter_press;
    logic              w_clear_press;
    logic [DATA_W-1:0] w_shifted;

    state_t            r_state;
    logic              r_wr_req;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_entry_word;
    logic [NC_W-1:0]   r_nib_count;
    logic              r_full;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;
`endif

    assign w_raw_keys = {i_Key_Clear, i_Key_Enter};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .i_Clk   (i_Clk),
                .i_Reset (i_Reset),
                .i_Key   (w_raw_keys[gi]),
                .o_Press (w_press[gi])
            );
        end
    endgenerate

    assign w_enter_press = w_press[0];
    assign w_clear_press = w_press[1];

    // New nibble enters at the bottom; the oldest nibble falls off the top.
    assign w_shifted = DATA_W'({r_entry_word, i_Sw_Nibble});

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_state      <= ST_ENTRY;
            r_wr_req     <= 1'b0;
            r_wr_addr    <= START_ADDR;
            r_wr_data    <= '0;
            r_entry_word <= '0;
            r_nib_count  <= '0;
            r_full       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    // Clear has priority over a simultaneous Enter.
                    if (w_clear_press) begin
                        r_entry_word <= '0;
                        r_nib_count  <= '0;
                    end else if (w_enter_press) begin
                        r_entry_word <= w_shifted;
                        if (r_nib_count == NIB_LAST) begin
                            r_nib_count <= '0;
                            r_wr_data   <= w_shifted;
                            r_wr_req    <= 1'b1;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_nib_count <= r_nib_count + NC_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    // Key events are simply not looked at here, so they drop.
                    if (i_Wr_Ack) begin
                        r_wr_req     <= 1'b0;
                        r_entry_word <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_checksum   <= r_checksum ^ r_wr_data;
`endif
                        if (&r_wr_addr) begin
                            r_full  <= 1'b1;
                            r_state <= ST_FULL;
                        end else begin
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                            r_state   <= ST_ENTRY;
                        end
                    end
                end
                ST_FULL: begin
                    // Absorbing until reset.
                end
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    assign o_Wr_Req     = r_wr_req;
    assign o_Wr_Addr    = r_wr_addr;
    assign o_Wr_Data    = r_wr_data;
    assign o_Entry_Word = r_entry_word;
    assign o_Nib_Count  = r_nib_count;
    assign o_State_Out  = r_state;
    assign o_Full       = r_full;
`ifdef LOADER_CHECKSUM_EN
    assign o_Checksum   = r_checksum;
`endif

endmodule
